umi_mux_arbiter: RTL and testbench

//  Transaction-aware arbiter and sequencer for the N:1 UMI mux datapath. Picks one

---
 rtl/umi_arb_pkg.sv | 16 +
 rtl/umi_arb_pick.sv | 29 ++
 rtl/umi_mux_arbiter.sv | 155 +++++++++++++++
 tb/tb_umi_mux_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_arb_pkg.sv
// Shared definitions for the UMI mux arbiter.
//   ARB_*       : arbitration mode encodings carried on arbmode
//   arb_state_e : transaction sequencer state (IDLE arbitrates, LOCK holds grant)
package umi_arb_pkg;

  localparam logic [1:0] ARB_PRIO = 2'b00;
  localparam logic [1:0] ARB_AGED = 2'b01;
  localparam logic [1:0] ARB_RR   = 2'b10;
  localparam logic [1:0] ARB_RSVD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/umi_arb_pick.sv
// Combinational picker: one-hot of the first asserted request found when
// scanning upward from ptr_i and wrapping from N-1 back to 0.
// With ptr_i = 0 this is a plain lowest-index priority picker.
//   req_i : request vector
//   ptr_i : starting index of the scan
//   gnt_o : one-hot winner, or zero when no request is set
module umi_arb_pick #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/umi_mux_arbiter.sv
// Transaction-aware arbiter/sequencer for an N:1 UMI mux. A grant chosen in
// IDLE is held from the first accepted beat until the EOM beat is accepted.
//   clk, reset          : clock, asynchronous active-high reset
//   arbmode             : 00 priority, 01 aged priority, 10/11 round robin
//   arbmask             : 1 = requester may not win a new grant
//   in_valid, in_eom    : per-input valid and end-of-message bit
//   in_ready            : per-input ready (grant & out_ready)
//   out_ready/out_valid : downstream handshake
//   grant, sel          : one-hot and binary select of the datapath input
//   locked              : high while a multi-beat transaction is in flight
module umi_mux_arbiter
  import umi_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int AGE  = 16,
  parameter int AGEW = $clog2(AGE + 1),
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      arbmode,
  input  logic [N-1:0]    arbmask,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_eom,
  output logic [N-1:0]    in_ready,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] sel,
  output logic            locked
);

  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(AGE);

  arb_state_e      state_q;
  logic [N-1:0]    lock_grant_q;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AGEW-1:0] age_q [N];
  logic [AGEW-1:0] age_d [N];

  logic [N-1:0]    elig, aged_elig, main_gnt, aged_gnt, arb_gnt;
  logic [SELW-1:0] main_ptr;
  logic            use_aged;
  logic            hs, eom;

  assign elig = in_valid & ~arbmask;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      aged_elig[i] = elig[i] && (age_q[i] == AGE_MAX);
    end
  end

  // Mode decode: round robin moves the scan start, aged mode lets any
  // requester that hit the threshold pre-empt the plain priority choice.
  always_comb begin
    main_ptr = '0;
    use_aged = 1'b0;
    case (arbmode)
      ARB_PRIO: main_ptr = '0;
      ARB_AGED: use_aged = |aged_elig;
      ARB_RR,
      ARB_RSVD: main_ptr = rr_ptr_q;
      default:  main_ptr = '0;
    endcase
  end

  umi_arb_pick #(.N(N), .SELW(SELW)) u_pick_main (
    .req_i (elig),
    .ptr_i (main_ptr),
    .gnt_o (main_gnt)
  );

  umi_arb_pick #(.N(N), .SELW(SELW)) u_pick_aged (
    .req_i (aged_elig),
    .ptr_i ('0),
    .gnt_o (aged_gnt)
  );

  assign arb_gnt = use_aged ? aged_gnt : main_gnt;

  // Grant is combinational in IDLE for zero-latency arbitration; gating with
  // reset keeps every output low for the whole time reset is asserted.
  assign grant     = reset ? '0 : ((state_q == LOCK) ? lock_grant_q : arb_gnt);
  assign out_valid = |(in_valid & grant);
  assign in_ready  = grant & {N{out_ready}};
  assign hs        = out_valid & out_ready;
  assign eom       = |(in_eom & grant);
  assign locked    = (state_q == LOCK);

  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel = sel | SELW'(i);
    end
  end

  // Transaction sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lock_grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs && !eom) begin
            state_q      <= LOCK;
            lock_grant_q <= grant;
          end
        end
        LOCK: begin
          if (hs && eom) begin
            state_q      <= IDLE;
            lock_grant_q <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          lock_grant_q <= '0;
        end
      endcase
    end
  end

  // Round-robin pointer advances past the winner only when a txn completes.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs && eom) begin
      rr_ptr_d = (sel == SELW'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

  // Age counters run in every mode so switching to aged mode sees real ages.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      age_d[i] = age_q[i];
      if (hs && grant[i]) begin
        age_d[i] = '0;
      end else if (in_valid[i] && !grant[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: tb/tb_umi_mux_arbiter.sv
module tb_umi_mux_arbiter;

  localparam int N    = 4;
  localparam int AGE  = 16;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      arbmode;
  logic [N-1:0]    arbmask;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_eom;
  logic [N-1:0]    in_ready;
  logic            out_ready;
  logic            out_valid;
  logic [N-1:0]    grant;
  logic [SELW-1:0] sel;
  logic            locked;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: who owns the output, the round-robin start point
  // and how long each requester has been waiting.
  bit m_lock;
  int m_owner;
  int m_rr;
  int m_age [N];
  int cur_g;

  always #5 clk = ~clk;

  umi_mux_arbiter #(.N(N), .AGE(AGE)) dut (
    .clk       (clk),
    .reset     (reset),
    .arbmode   (arbmode),
    .arbmask   (arbmask),
    .in_valid  (in_valid),
    .in_eom    (in_eom),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .grant     (grant),
    .sel       (sel),
    .locked    (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    m_lock  = 1'b0;
    m_owner = -1;
    m_rr    = 0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  // Winner index the arbiter should present this cycle, -1 for none.
  function automatic int mdl_pick();
    int g;
    g = -1;
    if (m_lock) return m_owner;
    if (arbmode == 2'd1) begin
      for (int i = 0; i < N; i++)
        if (g < 0 && in_valid[i] && !arbmask[i] && m_age[i] >= AGE) g = i;
      if (g >= 0) return g;
    end
    if (arbmode >= 2'd2) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && in_valid[(m_rr + k) % N] && !arbmask[(m_rr + k) % N]) g = (m_rr + k) % N;
    end else begin
      for (int i = 0; i < N; i++)
        if (g < 0 && in_valid[i] && !arbmask[i]) g = i;
    end
    return g;
  endfunction

  task automatic check_cycle();
    int g;
    logic [N-1:0] eg;
    logic ev;
    @(negedge clk);
    g  = mdl_pick();
    eg = '0;
    ev = 1'b0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ev    = in_valid[g];
    end
    chk("grant", grant, eg);
    chk("sel", sel, (g < 0) ? 0 : g);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, out_ready ? eg : '0);
    chk("locked", locked, m_lock);
    cur_g = g;
  endtask

  task automatic advance();
    bit hs, e;
    @(posedge clk);
    hs = (cur_g >= 0) && in_valid[cur_g] && out_ready;
    e  = (cur_g >= 0) && in_eom[cur_g];
    for (int i = 0; i < N; i++) begin
      if (hs && i == cur_g) m_age[i] = 0;
      else if (in_valid[i] && i != cur_g && m_age[i] < AGE) m_age[i]++;
    end
    if (!m_lock && hs && !e) begin
      m_lock  = 1'b1;
      m_owner = cur_g;
    end else if (m_lock && hs && e) begin
      m_lock = 1'b0;
    end
    if (hs && e) m_rr = (cur_g + 1) % N;
    #1;
  endtask

  task automatic cyc(input string tag, input logic [N-1:0] xg, input logic xl);
    check_cycle();
    chk({tag, "_grant"}, grant, xg);
    chk({tag, "_locked"}, locked, xl);
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_clear();
  endtask

  initial begin
    reset     = 1'b1;
    arbmode   = 2'd0;
    arbmask   = '0;
    in_valid  = 4'b1111;
    in_eom    = 4'b1111;
    out_ready = 1'b1;
    mdl_clear();

    // Reset holds every output low even with requests pending
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sel", sel, 0);
    do_reset();

    // Priority, all single-beat: input 0 always wins
    for (int k = 0; k < 4; k++) cyc("prio", 4'b0001, 1'b0);

    // Round robin from a clean pointer
    do_reset();
    arbmode = 2'd2;
    cyc("rr0", 4'b0001, 1'b0);
    cyc("rr1", 4'b0010, 1'b0);
    cyc("rr2", 4'b0100, 1'b0);
    cyc("rr3", 4'b1000, 1'b0);
    cyc("rr4", 4'b0001, 1'b0);

    // Three-beat burst on input 1, input 0 joins mid-burst
    do_reset();
    arbmode  = 2'd0;
    in_valid = 4'b0010;
    in_eom   = 4'b0000;
    cyc("burst1", 4'b0010, 1'b0);
    in_valid = 4'b0011;
    cyc("burst2", 4'b0010, 1'b1);
    in_eom   = 4'b0011;
    cyc("burst3", 4'b0010, 1'b1);
    in_valid = 4'b0001;
    cyc("burst_next", 4'b0001, 1'b0);

    // Aged: input 3 waits behind a streaming input 0
    do_reset();
    arbmode  = 2'd1;
    in_valid = 4'b1001;
    in_eom   = 4'b1111;
    for (int k = 0; k < 16; k++) cyc("aged_wait", 4'b0001, 1'b0);
    cyc("aged_win", 4'b1000, 1'b0);

    // Mask applied mid-transaction only affects the next arbitration
    do_reset();
    arbmode  = 2'd0;
    in_valid = 4'b0011;
    in_eom   = 4'b0000;
    cyc("mask1", 4'b0001, 1'b0);
    arbmask  = 4'b0001;
    cyc("mask2", 4'b0001, 1'b1);
    in_eom   = 4'b0001;
    cyc("mask3", 4'b0001, 1'b1);
    cyc("mask_next", 4'b0010, 1'b0);
    arbmask  = '0;

    // Asynchronous reset while locked and stalled
    do_reset();
    arbmode  = 2'd2;
    in_valid = 4'b0100;
    in_eom   = 4'b0000;
    cyc("lk1", 4'b0100, 1'b0);
    out_ready = 1'b0;
    cyc("lk2", 4'b0100, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_locked", locked, 0);
    chk("arst_sel", sel, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_clear();
    in_valid  = 4'b1111;
    in_eom    = 4'b1111;
    out_ready = 1'b1;
    cyc("post_rst", 4'b0001, 1'b0);

    // Random traffic against the reference model
    for (int k = 0; k < 2000; k++) begin
      arbmode   = 2'($urandom_range(0, 3));
      arbmask   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      in_valid  = N'($urandom);
      in_eom    = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      check_cycle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
